// File: rtl/floating_point_unit.sv
// floating_point_unit
//   Single-precision IEEE-754 execution block for the mips86 core. The datapath
//   is combinational and the result is captured in an output register.
//   Denormal inputs are treated as zero and denormal results flush to signed zero.
//   Any NaN input to ADD/SUB/MUL produces the canonical quiet NaN 32'h7FC00000.
//
// Ports
//   clk     in   1   system clock, result register updates on rising edge
//   reset   in   1   asynchronous active-low reset, clears result
//   a       in  32   operand A
//   b       in  32   operand B
//   cmd     in   4   0 ADD, 1 SUB, 2 MUL, 3 NEG, 4 ABS, others give zero
//   result  out 32   registered result
module floating_point_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  cmd,
  output logic [31:0] result
);

  typedef enum logic [3:0] {
    CMD_ADD = 4'd0,
    CMD_SUB = 4'd1,
    CMD_MUL = 4'd2,
    CMD_NEG = 4'd3,
    CMD_ABS = 4'd4
  } cmd_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Round to nearest even on a normalized 24-bit significand, then apply
  // overflow to infinity and underflow to signed zero.
  function automatic logic [31:0] pack_round(input logic              s,
                                             input logic signed [9:0] e,
                                             input logic [23:0]       m,
                                             input logic              g,
                                             input logic              rs);
    logic [24:0]       mr;
    logic signed [9:0] ef;
    logic [22:0]       f;
    mr = {1'b0, m} + {24'b0, g & (rs | m[0])};
    ef = e;
    f  = mr[22:0];
    if (mr[24]) begin
      ef = e + 10'sd1;
      f  = mr[23:1];
    end
    if (ef >= 10'sd255)
      return {s, 8'hFF, 23'b0};
    else if (ef <= 10'sd0)
      return {s, 31'b0};
    else
      return {s, ef[7:0], f};
  endfunction

  // Operand classification
  logic       sa, sb_eff;
  logic [7:0] ea, eb;
  logic [22:0] fa, fb;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sa     = a[31];
  assign sb_eff = (cmd == CMD_SUB) ? ~b[31] : b[31];
  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign fa     = a[22:0];
  assign fb     = b[22:0];
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (fa == '0);
  assign b_inf  = (eb == 8'hFF) && (fb == '0);
  assign a_nan  = (ea == 8'hFF) && (fa != '0);
  assign b_nan  = (eb == 8'hFF) && (fb != '0);

  // Add / subtract
  logic              swap, big_s, sml_s;
  logic [7:0]        big_e, sml_e, d;
  logic [23:0]       big_m, sml_m;
  logic [49:0]       sml_wide;
  logic [26:0]       aligned, norm;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic signed [9:0] add_e;
  logic [31:0]       add_res;

  always_comb begin
    swap  = {eb, fb} > {ea, fa};
    big_s = swap ? sb_eff : sa;
    sml_s = swap ? sa : sb_eff;
    big_e = swap ? eb : ea;
    sml_e = swap ? ea : eb;
    big_m = swap ? {1'b1, fb} : {1'b1, fa};
    sml_m = swap ? {1'b1, fa} : {1'b1, fb};
    d     = big_e - sml_e;

    // Smaller operand keeps 24 bits + guard + round, everything below is ORed
    // into sticky; far-away operands survive only as a sticky bit.
    sml_wide = {sml_m, 26'b0} >> d;
    aligned  = (d >= 8'd26) ? 27'd1 : {sml_wide[49:24], |sml_wide[23:0]};

    if (big_s == sml_s)
      sum = {1'b0, big_m, 3'b000} + {1'b0, aligned};
    else
      sum = {1'b0, big_m, 3'b000} - {1'b0, aligned};

    lz = '0;
    for (int unsigned i = 0; i < 27; i++)
      if (sum[i]) lz = 5'(26 - i);

    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      add_e = $signed({2'b00, big_e}) + 10'sd1;
    end else begin
      norm  = sum[26:0] << lz;
      add_e = $signed({2'b00, big_e}) - $signed({5'b00000, lz});
    end

    if (a_nan || b_nan)
      add_res = QNAN;
    else if (a_inf && b_inf)
      add_res = (sa != sb_eff) ? QNAN : a;
    else if (a_inf)
      add_res = a;
    else if (b_inf)
      add_res = {sb_eff, b[30:0]};
    else if (a_zero && b_zero)
      add_res = {sa & sb_eff, 31'b0};
    else if (a_zero)
      add_res = {sb_eff, b[30:0]};
    else if (b_zero)
      add_res = a;
    else if (sum == '0)
      add_res = '0;
    else
      add_res = pack_round(big_s, add_e, norm[26:3], norm[2], |norm[1:0]);
  end

  // Multiply
  logic [47:0]       prod;
  logic signed [9:0] mul_e;
  logic              s_mul;
  logic [31:0]       mul_res;

  always_comb begin
    s_mul = a[31] ^ b[31];
    prod  = {24'b0, 1'b1, fa} * {24'b0, 1'b1, fb};
    mul_e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

    if (a_nan || b_nan)
      mul_res = QNAN;
    else if ((a_inf && b_zero) || (b_inf && a_zero))
      mul_res = QNAN;
    else if (a_inf || b_inf)
      mul_res = {s_mul, 8'hFF, 23'b0};
    else if (a_zero || b_zero)
      mul_res = {s_mul, 31'b0};
    else if (prod[47])
      mul_res = pack_round(s_mul, mul_e + 10'sd1, prod[47:24], prod[23], |prod[22:0]);
    else
      mul_res = pack_round(s_mul, mul_e, prod[46:23], prod[22], |prod[21:0]);
  end

  logic [31:0] nxt;

  always_comb begin
    nxt = '0;
    case (cmd)
      CMD_ADD, CMD_SUB: nxt = add_res;
      CMD_MUL:          nxt = mul_res;
      CMD_NEG:          nxt = {~a[31], a[30:0]};
      CMD_ABS:          nxt = {1'b0, a[30:0]};
      default:          nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      result <= '0;
    else
      result <= nxt;
  end

endmodule

// File: tb/tb_floating_point_unit.sv
// Testbench for floating_point_unit. Expected results come from a reference
// model built on double-precision reals (correctly rounded back to single),
// pushed to a scoreboard queue at issue and compared one cycle later.
module tb_floating_point_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  cmd = '0;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  floating_point_unit dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .cmd    (cmd),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  function automatic real f2r(input logic [31:0] x);
    logic [10:0] e11;
    e11 = 11'(x[30:23]) + 11'd896;
    return $bitstoreal({x[31], e11, x[22:0], 29'b0});
  endfunction

  // Correctly rounded double -> single, with flush of tiny results.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] q;
    int          e;
    logic [24:0] m;
    logic        up;
    q = $realtobits(r);
    if (q[62:0] == '0) return '0;
    e  = int'(q[62:52]) - 896;
    up = q[28] & ((|q[27:0]) | q[29]);
    m  = {2'b01, q[51:29]} + 25'(up);
    if (m[24]) begin
      e++;
      m = m >> 1;
    end
    if (e >= 255) return {q[63], 8'hFF, 23'h0};
    if (e <= 0)   return {q[63], 31'h0};
    return {q[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    logic xz, yz, xi, yi, xn, yn, ys;
    xz = (x[30:23] == 8'h00);
    yz = (y[30:23] == 8'h00);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    case (c)
      4'd0, 4'd1: begin
        ys = (c == 4'd1) ? ~y[31] : y[31];
        if (xn || yn)      return 32'h7FC00000;
        if (xi && yi)      return (x[31] != ys) ? 32'h7FC00000 : x;
        if (xi)            return x;
        if (yi)            return {ys, y[30:0]};
        if (xz && yz)      return {x[31] & ys, 31'h0};
        if (xz)            return {ys, y[30:0]};
        if (yz)            return x;
        return r2f(f2r(x) + f2r({ys, y[30:0]}));
      end
      4'd2: begin
        if (xn || yn)                  return 32'h7FC00000;
        if ((xi && yz) || (yi && xz))  return 32'h7FC00000;
        if (xi || yi)                  return {x[31] ^ y[31], 8'hFF, 23'h0};
        if (xz || yz)                  return {x[31] ^ y[31], 31'h0};
        return r2f(f2r(x) * f2r(y));
      end
      4'd3:    return {~x[31], x[30:0]};
      4'd4:    return {1'b0, x[30:0]};
      default: return 32'h0;
    endcase
  endfunction

  // Compare the operation issued last cycle (captured at the intervening
  // rising edge), then drive the next one.
  task automatic issue(input string tag, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    if (exp_q.size() > 0) check_eq(tag_q.pop_front(), result, exp_q.pop_front());
    cmd = c;
    a   = x;
    b   = y;
    exp_q.push_back(model(c, x, y));
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    @(negedge clk);
    while (exp_q.size() > 0) check_eq(tag_q.pop_front(), result, exp_q.pop_front());
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] specials[6];
    specials = '{32'h00000000, 32'h80000000, 32'h00012345,
                 32'h7F800000, 32'hFF800000, 32'h7FC12345};
    if ($urandom_range(0, 9) == 0) return specials[$urandom_range(0, 5)];
    return {1'($urandom), 8'($urandom_range(110, 145)), 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] x, y;
    logic [3:0]  c;

    // Reset held: result stays zero whatever the inputs and clock do.
    a = 32'h4048F5C3; b = 32'h3F800000; cmd = 4'd0;
    repeat (3) begin
      @(negedge clk);
      check_eq("reset_hold", result, 32'h0);
    end
    reset = 1'b1;

    issue("add_identity",  4'd0, 32'h4048F5C3, 32'h00000000);
    issue("add_double",    4'd0, 32'h4048F5C3, 32'h4048F5C3);
    issue("add_align",     4'd0, 32'h4048F5C3, 32'h40C8F5C3);
    issue("sub_cancel",    4'd1, 32'h3F800000, 32'h3F800000);
    issue("mul_2x3",       4'd2, 32'h40000000, 32'h40400000);
    issue("inf_minus_inf", 4'd0, 32'h7F800000, 32'hFF800000);
    issue("mul_overflow",  4'd2, 32'h7F000000, 32'h7F000000);
    issue("cmd_unused",    4'd9, 32'h4048F5C3, 32'h3F800000);
    issue("zero_times_inf",4'd2, 32'h00000000, 32'hFF800000);
    issue("neg_zero_sum",  4'd0, 32'h80000000, 32'h80000000);
    issue("inf_plus_fin",  4'd1, 32'h3F800000, 32'h7F800000);
    issue("denorm_flush",  4'd0, 32'h00012345, 32'h80054321);
    issue("neg",           4'd3, 32'h4048F5C3, 32'h12345678);
    issue("abs",           4'd4, 32'hC048F5C3, 32'h12345678);
    drain();

    // Asynchronous reset away from any clock edge.
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_eq("async_reset", result, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 300; i++) begin
      c = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(3, 15));
      x = rand_fp();
      case ($urandom_range(0, 2))
        0:       y = rand_fp();
        1:       y = {1'($urandom), x[30:4], 4'($urandom)};
        default: y = {1'($urandom), 8'($urandom_range(110, 145)), 23'($urandom)};
      endcase
      issue("rand", c, x, y);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
